// File: rtl/addsub_multicycle.sv
// addsub_multicycle: multi-cycle adder/subtractor for the ULA datapath.
// One CHUNK-wide carry-chain slice is reused for WIDTH/CHUNK cycles; the
// inter-chunk carry is held in a flop. Operand and result sides use
// valid/ready handshakes.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   in_valid   operand request
//   in_ready   block can accept operands (high in IDLE only)
//   op_sub     0: a+b, 1: a-b (sampled with the operands)
//   a, b       operands (WIDTH bits)
//   out_valid  result/flags valid (high in DONE only)
//   out_ready  consumer takes the result
//   s          result (WIDTH bits)
//   cout       carry out of the MSB (subtract: 1 = no borrow)
//   ovf        signed overflow
//   zero       s == 0
//
// Build option: define ADDSUB_SATURATE_EN to clamp s to the signed limit on
// overflow; otherwise s wraps modulo 2^WIDTH.

module addsub_multicycle #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned SH_W   = $clog2(WIDTH + 1);

    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Reject a chunk size that does not tile the operand width
    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("addsub_multicycle: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [SH_W-1:0]  sh;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] s_run;
    logic [WIDTH-1:0] s_fin;
    logic             msb_cin;
    logic             ovf_run;
    logic             last;

    // Next-state and chunk datapath
    always_comb begin
        state_next = state;
        sh         = SH_W'(cnt) * SH_W'(CHUNK);
        a_chunk    = CHUNK'(a_q >> sh);
        b_chunk    = CHUNK'(b_q >> sh);
        sum        = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry);
        s_run      = (s & ~(CHUNK_MASK << sh)) | (WIDTH'(sum[CHUNK-1:0]) << sh);
        // Carry into the MSB recovered from the MSB sum bit
        msb_cin    = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ s_run[WIDTH-1];
        ovf_run    = msb_cin ^ sum[CHUNK];
`ifdef ADDSUB_SATURATE_EN
        // Operands share a sign on overflow, so a_q's MSB gives the direction
        if (ovf_run) begin
            s_fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            s_fin = s_run;
        end
`else
        s_fin      = s_run;
`endif
        last       = (cnt == CNT_W'(NCHUNK - 1));

        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // State, operand, carry and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            s         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b ^ {WIDTH{op_sub}};
                        carry <= op_sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    s     <= last ? s_fin : s_run;
                    carry <= sum[CHUNK];
                    cnt   <= cnt + CNT_W'(1);
                    if (last) begin
                        cout <= sum[CHUNK];
                        ovf  <= ovf_run;
                        zero <= (s_fin == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
